// File: rtl/vanilla_scoreboard_tracker_pkg.sv
// Scoreboard info types shared by the vanilla scoreboard tracker and its stall profiler.
package vanilla_scoreboard_tracker_pkg;

  localparam int reg_els_gp          = 32;
  localparam int reg_addr_width_gp   = 5;
  localparam int sb_stall_cat_num_gp = 7;

  typedef struct packed {
    logic remote_dram_seq_load;
    logic remote_dram_load;
    logic remote_dram_amo;
    logic remote_global_load;
    logic remote_group_load;
    logic idiv;
  } vanilla_isb_info_s;

  typedef struct packed {
    logic remote_dram_seq_load;
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic fdiv_fsqrt;
  } vanilla_fsb_info_s;

  // Priority order, highest first; enum value doubles as the blocking-vector bit index.
  typedef enum logic [2:0] {
    e_sb_stall_dram_seq_load,
    e_sb_stall_dram_load,
    e_sb_stall_dram_amo,
    e_sb_stall_global_load,
    e_sb_stall_group_load,
    e_sb_stall_div,
    e_sb_stall_unattributed
  } vanilla_sb_stall_cat_e;

  function automatic logic [sb_stall_cat_num_gp-2:0] isb_cats(input vanilla_isb_info_s s);
    return {s.idiv, s.remote_group_load, s.remote_global_load,
            s.remote_dram_amo, s.remote_dram_load, s.remote_dram_seq_load};
  endfunction

  function automatic logic [sb_stall_cat_num_gp-2:0] fsb_cats(input vanilla_fsb_info_s s);
    return {s.fdiv_fsqrt, s.remote_group_load, s.remote_global_load,
            1'b0, s.remote_dram_load, s.remote_dram_seq_load};
  endfunction

endpackage

// File: rtl/vanilla_sb_sat_accum.sv
// Saturating accumulator: adds add_i when v_i, holds at all-ones, clear_i wins over v_i.
module vanilla_sb_sat_accum #(
  parameter int width_p     = 32,
  parameter int add_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   v_i,
  input  logic [add_width_p-1:0] add_i,
  output logic [width_p-1:0]     cnt_o
);

  localparam int sum_width_lp = ((width_p > add_width_p) ? width_p : add_width_p) + 1;

  logic [sum_width_lp-1:0] sum;

  always_comb begin
    sum = sum_width_lp'(cnt_o) + sum_width_lp'(add_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_o <= '0;
    end else if (v_i) begin
      cnt_o <= (|sum[sum_width_lp-1:width_p]) ? '1 : sum[width_p-1:0];
    end
  end

endmodule

// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Attributes ID dependency stalls to scoreboard categories and measures
// set-to-clear latency of every scoreboarded int/fp register.
module vanilla_scoreboard_stall_profiler
  import vanilla_scoreboard_tracker_pkg::*;
#(
  parameter int counter_width_p = 32,
  parameter int ts_width_p      = 32,
  localparam int reg_addr_width_lp = reg_addr_width_gp
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,
  input  logic                                               en_i,
  input  logic                                               clear_i,
  input  logic                                               stall_depend_i,
  input  logic [reg_addr_width_lp-1:0]                       id_rs1_i,
  input  logic [reg_addr_width_lp-1:0]                       id_rs2_i,
  input  logic [reg_addr_width_lp-1:0]                       id_frs1_i,
  input  logic [reg_addr_width_lp-1:0]                       id_frs2_i,
  input  logic [reg_addr_width_lp-1:0]                       id_frs3_i,
  input  logic                                               id_read_rs1_i,
  input  logic                                               id_read_rs2_i,
  input  logic                                               id_read_frs1_i,
  input  logic                                               id_read_frs2_i,
  input  logic                                               id_read_frs3_i,
  input  vanilla_isb_info_s [reg_els_gp-1:0]                 int_sb_i,
  input  vanilla_fsb_info_s [reg_els_gp-1:0]                 float_sb_i,
  output logic [sb_stall_cat_num_gp-1:0][counter_width_p-1:0] stall_cnt_o,
  output logic [counter_width_p-1:0]                         lat_cnt_o,
  output logic [counter_width_p-1:0]                         lat_sum_o,
  output logic [counter_width_p-1:0]                         lat_max_o
);

  localparam int entries_lp       = 2 * reg_els_gp;
  localparam int lat_add_width_lp = ts_width_p + $clog2(entries_lp);
  localparam int fall_width_lp    = $clog2(entries_lp + 1);
  localparam int max_width_lp     = (counter_width_p > ts_width_p) ? counter_width_p : ts_width_p;

  logic [sb_stall_cat_num_gp-2:0] blk;
  vanilla_sb_stall_cat_e          stall_cat;
  logic [sb_stall_cat_num_gp-1:0] stall_hit;

  always_comb begin
    blk = '0;
    if (id_read_rs1_i && (id_rs1_i != '0)) blk = blk | isb_cats(int_sb_i[id_rs1_i]);
    if (id_read_rs2_i && (id_rs2_i != '0)) blk = blk | isb_cats(int_sb_i[id_rs2_i]);
    if (id_read_frs1_i) blk = blk | fsb_cats(float_sb_i[id_frs1_i]);
    if (id_read_frs2_i) blk = blk | fsb_cats(float_sb_i[id_frs2_i]);
    if (id_read_frs3_i) blk = blk | fsb_cats(float_sb_i[id_frs3_i]);
    // Scan from lowest priority upward so the highest-priority set bit is written last.
    stall_cat = e_sb_stall_unattributed;
    for (int unsigned i = sb_stall_cat_num_gp - 1; i > 0; i--) begin
      if (blk[i-1]) stall_cat = vanilla_sb_stall_cat_e'(3'(i - 1));
    end
    stall_hit = '0;
    stall_hit[stall_cat] = en_i & stall_depend_i;
  end

  for (genvar c = 0; c < sb_stall_cat_num_gp; c++) begin : g_stall
    vanilla_sb_sat_accum #(.width_p(counter_width_p), .add_width_p(1)) u_acc (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear_i),
      .v_i     (stall_hit[c]),
      .add_i   (1'b1),
      .cnt_o   (stall_cnt_o[c])
    );
  end

  logic [entries_lp-1:0]       any_now, prev_r, rise, fall;
  logic [ts_width_p-1:0]       ts_r;
  logic [ts_width_p-1:0]       slot_r [entries_lp];
  logic [ts_width_p-1:0]       lat, cyc_max;
  logic [lat_add_width_lp-1:0] lat_add;
  logic [fall_width_lp-1:0]    fall_cnt;
  logic [max_width_lp-1:0]     cyc_max_w;
  logic [counter_width_p-1:0]  cyc_max_sat;

  always_comb begin
    any_now = '0;
    for (int unsigned r = 0; r < reg_els_gp; r++) begin
      any_now[r]              = |int_sb_i[r];
      any_now[reg_els_gp + r] = |float_sb_i[r];
    end
    rise = any_now & ~prev_r;
    fall = ~any_now & prev_r;
  end

  always_comb begin
    lat      = '0;
    cyc_max  = '0;
    lat_add  = '0;
    fall_cnt = '0;
    for (int unsigned e = 0; e < entries_lp; e++) begin
      if (fall[e]) begin
        lat      = ts_r - slot_r[e];
        lat_add  = lat_add + lat_add_width_lp'(lat);
        fall_cnt = fall_cnt + fall_width_lp'(1);
        if (lat > cyc_max) cyc_max = lat;
      end
    end
    cyc_max_w   = max_width_lp'(cyc_max);
    cyc_max_sat = (cyc_max_w > max_width_lp'({counter_width_p{1'b1}}))
                ? '1 : counter_width_p'(cyc_max_w);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_r   <= '0;
      prev_r <= '0;
      for (int unsigned e = 0; e < entries_lp; e++) slot_r[e] <= '0;
    end else begin
      prev_r <= any_now;
      if (en_i) begin
        ts_r <= ts_r + ts_width_p'(1);
        for (int unsigned e = 0; e < entries_lp; e++) begin
          if (rise[e]) slot_r[e] <= ts_r;
        end
      end
    end
  end

  vanilla_sb_sat_accum #(.width_p(counter_width_p), .add_width_p(fall_width_lp)) u_lat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .v_i     (en_i),
    .add_i   (fall_cnt),
    .cnt_o   (lat_cnt_o)
  );

  vanilla_sb_sat_accum #(.width_p(counter_width_p), .add_width_p(lat_add_width_lp)) u_lat_sum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .v_i     (en_i),
    .add_i   (lat_add),
    .cnt_o   (lat_sum_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      lat_max_o <= '0;
    end else if (en_i && (cyc_max_sat > lat_max_o)) begin
      lat_max_o <= cyc_max_sat;
    end
  end

endmodule

// File: tb/tb_vanilla_scoreboard_stall_profiler.sv
// Directed bench for the scoreboard stall profiler: a 32-bit-counter instance and a 4-bit one share stimulus.
module tb_vanilla_scoreboard_stall_profiler;
  import vanilla_scoreboard_tracker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, clear, stall;
  logic [4:0] rs1, rs2, frs1, frs2, frs3;
  logic rd_rs1, rd_rs2, rd_frs1, rd_frs2, rd_frs3;
  vanilla_isb_info_s [reg_els_gp-1:0] int_sb;
  vanilla_fsb_info_s [reg_els_gp-1:0] float_sb;

  logic [sb_stall_cat_num_gp-1:0][31:0] stall_cnt;
  logic [31:0] lat_cnt, lat_sum, lat_max;
  logic [sb_stall_cat_num_gp-1:0][3:0] stall_cnt4;
  logic [3:0] lat_cnt4, lat_sum4, lat_max4;

  int tests = 0;
  int fails = 0;

  vanilla_scoreboard_stall_profiler #(.counter_width_p(32), .ts_width_p(32)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .stall_depend_i(stall),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_frs1_i(frs1), .id_frs2_i(frs2), .id_frs3_i(frs3),
    .id_read_rs1_i(rd_rs1), .id_read_rs2_i(rd_rs2), .id_read_frs1_i(rd_frs1),
    .id_read_frs2_i(rd_frs2), .id_read_frs3_i(rd_frs3),
    .int_sb_i(int_sb), .float_sb_i(float_sb),
    .stall_cnt_o(stall_cnt), .lat_cnt_o(lat_cnt), .lat_sum_o(lat_sum), .lat_max_o(lat_max)
  );

  vanilla_scoreboard_stall_profiler #(.counter_width_p(4), .ts_width_p(32)) dut4 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .stall_depend_i(stall),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_frs1_i(frs1), .id_frs2_i(frs2), .id_frs3_i(frs3),
    .id_read_rs1_i(rd_rs1), .id_read_rs2_i(rd_rs2), .id_read_frs1_i(rd_frs1),
    .id_read_frs2_i(rd_frs2), .id_read_frs3_i(rd_frs3),
    .int_sb_i(int_sb), .float_sb_i(float_sb),
    .stall_cnt_o(stall_cnt4), .lat_cnt_o(lat_cnt4), .lat_sum_o(lat_sum4), .lat_max_o(lat_max4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    stall = 1'b0;
    rs1 = '0; rs2 = '0; frs1 = '0; frs2 = '0; frs3 = '0;
    rd_rs1 = 1'b0; rd_rs2 = 1'b0; rd_frs1 = 1'b0; rd_frs2 = 1'b0; rd_frs3 = 1'b0;
    int_sb = '0;
    float_sb = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    en = 1'b1; clear = 1'b0; reset = 1'b1;
    idle();
    ticks(2);
    for (int c = 0; c < sb_stall_cat_num_gp; c++) chk($sformatf("reset_stall%0d", c), stall_cnt[c], 0);
    chk("reset_lat_cnt", lat_cnt, 0);
    chk("reset_lat_sum", lat_sum, 0);
    chk("reset_lat_max", lat_max, 0);
    reset = 1'b0;

    // x5 carries both DRAM load and idiv: DRAM_LOAD wins
    stall = 1'b1; rd_rs1 = 1'b1; rs1 = 5'd5;
    int_sb[5].remote_dram_load = 1'b1; int_sb[5].idiv = 1'b1;
    ticks(10);
    chk("dram_load_10", stall_cnt[e_sb_stall_dram_load], 10);
    chk("div_0", stall_cnt[e_sb_stall_div], 0);
    idle();
    tick();
    chk("x5_lat_cnt", lat_cnt, 1);
    chk("x5_lat_sum", lat_sum, 10);
    chk("x5_lat_max", lat_max, 10);

    // x0 never blocks
    stall = 1'b1; rd_rs1 = 1'b1; rs1 = 5'd0; int_sb[0] = '1;
    tick();
    chk("x0_unattr", stall_cnt[e_sb_stall_unattributed], 1);
    chk("x0_no_div", stall_cnt[e_sb_stall_div], 0);

    idle(); stall = 1'b1; rd_frs1 = 1'b1; frs1 = 5'd2; float_sb[2].fdiv_fsqrt = 1'b1;
    tick();
    idle(); stall = 1'b1; rd_rs2 = 1'b1; rs2 = 5'd3; int_sb[3].remote_global_load = 1'b1;
    rd_frs3 = 1'b1; frs3 = 5'd7; float_sb[7].remote_group_load = 1'b1;
    tick();
    idle(); stall = 1'b1; frs2 = 5'd8; float_sb[8].remote_dram_seq_load = 1'b1;
    rd_rs1 = 1'b1; rs1 = 5'd6; int_sb[6].remote_dram_amo = 1'b1;
    tick();
    chk("fdiv_as_div", stall_cnt[e_sb_stall_div], 1);
    chk("global_over_group", stall_cnt[e_sb_stall_global_load], 1);
    chk("group_0", stall_cnt[e_sb_stall_group_load], 0);
    chk("amo_1", stall_cnt[e_sb_stall_dram_amo], 1);
    chk("unread_seq_0", stall_cnt[e_sb_stall_dram_seq_load], 0);
    idle();
    tick();

    // f3 outstanding across a clear that coincides with a stall
    float_sb[3].remote_global_load = 1'b1;
    tick();
    clear = 1'b1; stall = 1'b1;
    tick();
    clear = 1'b0; stall = 1'b0;
    for (int c = 0; c < sb_stall_cat_num_gp; c++) chk($sformatf("clr_stall%0d", c), stall_cnt[c], 0);
    chk("clr_lat_cnt", lat_cnt, 0);
    chk("clr_lat_sum", lat_sum, 0);
    chk("clr_lat_max", lat_max, 0);
    ticks(5);
    float_sb[3].remote_global_load = 1'b0;
    tick();
    chk("f3_lat_cnt", lat_cnt, 1);
    chk("f3_lat_sum", lat_sum, 7);
    chk("f3_lat_max", lat_max, 7);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    float_sb[9].remote_dram_load = 1'b1;
    ticks(7);
    int_sb[4].remote_group_load = 1'b1;
    ticks(5);
    float_sb[9].remote_dram_load = 1'b0; int_sb[4].remote_group_load = 1'b0;
    tick();
    chk("dual_lat_cnt", lat_cnt, 2);
    chk("dual_lat_sum", lat_sum, 17);
    chk("dual_lat_max", lat_max, 12);
    chk("dual_lat_sum_sat4", lat_sum4, 15);
    chk("dual_lat_cnt4", lat_cnt4, 2);
    chk("dual_lat_max4", lat_max4, 12);

    en = 1'b0; stall = 1'b1;
    ticks(3);
    chk("en_off_unattr", stall_cnt[e_sb_stall_unattributed], 0);
    en = 1'b1; stall = 1'b0;

    stall = 1'b1; rd_rs1 = 1'b1; rs1 = 5'd7; int_sb[7].remote_group_load = 1'b1;
    ticks(14);
    chk("group4_14", stall_cnt4[e_sb_stall_group_load], 14);
    ticks(3);
    chk("group4_sat", stall_cnt4[e_sb_stall_group_load], 15);
    chk("group32_17", stall_cnt[e_sb_stall_group_load], 17);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
